// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//   Instruction fetch stage for the pipelined core. Owns the fetch PC, issues
//   in-order word requests to instruction memory and buffers returned words in
//   a small prefetch FIFO. Decode takes them through a valid/ready handshake.
//   A redirect flushes the FIFO and discards responses still in flight.
//
//   Build option: define FETCH_BYPASS_EN to forward a response straight to
//   decode in its arrival cycle when the FIFO is empty. Without it, nothing
//   on imem_rsp_* reaches instr_* in the same cycle.
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Prefetch storage and its bookkeeping
   logic [31:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_discard;
   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_head_pc;

   logic [CNT_W:0]   w_inflight;
   logic             w_req_valid;
   logic             w_req_fire;
   logic             w_rsp_drop;
   logic             w_rsp_keep;
   logic             w_fifo_empty;
   logic             w_bypass;
   logic             w_consume;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_out_next;
   logic [31:0]      w_redirect_pc;
   logic             w_unused;

   // The low two bits of the redirect target are forced to zero.
   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
   assign w_unused      = &{1'b0, redirect_pc[1:0]};

   // Credit: buffered words plus requests in flight never exceed DEPTH, so a
   // returning word always has a FIFO slot waiting for it.
   assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_req_valid  = !rst && !redirect_valid && (w_inflight < (CNT_W+1)'(DEPTH));
   assign w_req_fire   = w_req_valid && imem_req_ready;

   // Responses owed to requests issued before a redirect are dropped.
   assign w_rsp_drop   = (r_discard != '0);
   assign w_rsp_keep   = imem_rsp_valid && !w_rsp_drop && !redirect_valid;
   assign w_fifo_empty = (r_count == '0);

`ifdef FETCH_BYPASS_EN
   assign w_bypass     = w_fifo_empty && w_rsp_keep;
`else
   assign w_bypass     = 1'b0;
`endif

   // A pop during a redirect is ignored: the whole FIFO is being flushed.
   assign w_consume    = instr_valid && instr_ready && !redirect_valid;
   assign w_pop        = w_consume && !w_fifo_empty;
   // A bypassed word that decode takes immediately never occupies a slot.
   assign w_push       = w_rsp_keep && !(w_bypass && instr_ready);

   // Requests and responses in the same cycle cancel out.
   assign w_out_next   = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;

   assign instr_valid = !w_fifo_empty || w_bypass;
   assign instr       = !w_fifo_empty ? r_mem[r_rd_ptr] :
                        (w_bypass ? imem_rsp_data : NOP_INSTR);
   assign instr_pc    = r_head_pc;

   // Control state: PCs, FIFO pointers, credit and discard accounting
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_head_pc     <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old
            // path, including requests whose responses are pending.
            r_fetch_pc <= w_redirect_pc;
            r_head_pc  <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_discard  <= w_out_next;
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (imem_rsp_valid && w_rsp_drop) begin
               r_discard <= r_discard - 1'b1;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_consume) begin
               r_head_pc <= r_head_pc + 32'd4;
            end
         end
      end
   end

   // FIFO data storage
   // NOTE: the data array has no reset; r_count alone decides which entries
   // are meaningful, so clearing the words would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= imem_rsp_data;
      end
   end

endmodule
